// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: default geometry and clear-FSM encodings.
package register_file_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/register_file_cell.sv
// One storage word: async reset, synchronous clear with priority over load.
module register_cell
  import register_file_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with hardwired zero register and a sequenced clear.
//   state    | meaning
//   ST_IDLE  | normal operation, writes accepted, clr starts a clear
//   ST_CLEAR | zeroing register cnt_q each edge (1..DEPTH-1), writes and clr ignored
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              clr,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              busy
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0]  rdata_b_q, rdata_b_d;
  logic              wr_ok;
  logic [WIDTH-1:0]  regs [DEPTH];

  // clr beats a simultaneous write; nothing is written while clearing
  assign wr_ok = we && (waddr != '0) && (state_q == ST_IDLE) && !clr;

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_cell
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
    register_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .ld  (wr_ok && (waddr == IDX)),
      .clr ((state_q == ST_CLEAR) && (cnt_q == IDX)),
      .d   (wdata),
      .q   (regs[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // write-through: a port reading the word being written sees the new data
  always_comb begin
    rdata_a_d = regs[raddr_a];
    rdata_b_d = regs[raddr_b];
    if (wr_ok && (raddr_a == waddr)) begin
      rdata_a_d = wdata;
    end
    if (wr_ok && (raddr_b == waddr)) begin
      rdata_b_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;
  assign busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expectations.
module tb_register_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic       clr;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles = 0;

  register_file dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .clr     (clr),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(8'h11 * i));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 30 && busy; i++) tick();
    chk(tag, busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      tick();
      chk({tag, "_a"}, rdata_a, 8'h00);
      chk({tag, "_b"}, rdata_b, 8'h00);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; clr = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rda", rdata_a, 8'h00);
    rst = 1'b0;

    // post-reset contents
    check_all_zero("init");
    chk("init_busy", busy, 1'b0);

    // basic writes, independent ports
    wr(3'd3, 8'hA5);
    wr(3'd5, 8'h3C);
    raddr_a = 3'd3; raddr_b = 3'd5;
    tick();
    chk("rd_r3", rdata_a, 8'hA5);
    chk("rd_r5", rdata_b, 8'h3C);
    raddr_b = 3'd3;
    tick();
    chk("same_a", rdata_a, 8'hA5);
    chk("same_b", rdata_b, 8'hA5);

    // register 0 is hardwired, including on the bypass path
    wr(3'd0, 8'hFF);
    raddr_a = 3'd0;
    tick();
    chk("r0_zero", rdata_a, 8'h00);
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0;
    tick();
    we = 1'b0;
    chk("r0_nobyp", rdata_a, 8'h00);

    // bypass on both ports
    we = 1'b1; waddr = 3'd2; wdata = 8'h77; raddr_a = 3'd2; raddr_b = 3'd2;
    tick();
    we = 1'b0;
    chk("byp_a", rdata_a, 8'h77);
    chk("byp_b", rdata_b, 8'h77);

    // clear with a simultaneous write to r4
    fill_all();
    clr = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'hEE;
    busy_cycles = 0;
    tick();
    clr = 1'b0; we = 1'b0;
    chk("clr_busy", busy, 1'b1);
    raddr_a = 3'd4; raddr_b = 3'd7;
    tick();
    chk("clr_r4_drop", rdata_a, 8'h44);
    chk("clr_r7_old", rdata_b, 8'h77);
    raddr_a = 3'd1;
    tick();
    chk("clr_r1_done", rdata_a, 8'h00);
    wait_idle("clr_end");
    chk("clr_len", busy_cycles, 7);
    check_all_zero("clr");

    // clr and writes held during a running clear
    fill_all();
    clr = 1'b1;
    busy_cycles = 0;
    tick();
    we = 1'b1; waddr = 3'd6; wdata = 8'h99;
    for (int i = 0; i < 30 && busy; i++) tick();
    clr = 1'b0; we = 1'b0;
    chk("reclr_idle", busy, 1'b0);
    tick();
    chk("reclr_len", busy_cycles, 7);
    raddr_a = 3'd6; raddr_b = 3'd7;
    tick();
    chk("reclr_r6", rdata_a, 8'h00);
    chk("reclr_r7", rdata_b, 8'h00);

    // async reset in the middle of a clear
    fill_all();
    raddr_a = 3'd7; raddr_b = 3'd6;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1'b1);
    chk("pre_rst_rda", rdata_a, 8'h77);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_rda", rdata_a, 8'h00);
    chk("arst_rdb", rdata_b, 8'h00);
    we = 1'b1; waddr = 3'd5; wdata = 8'h55;
    tick();
    we = 1'b0;
    rst = 1'b0;
    check_all_zero("after_rst");
    chk("after_rst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
